plic_arbiter: RTL and testbench
===============================

Name: plic_arbiter

Overview:
- Memory-mapped interrupt arbiter between external interrupt sources and the CPU core's single external-interrupt input.
- Each source has a gateway state machine: idle, then pending, then claimed, then idle again. Sources are also gated by per-source enable, priority and a global threshold.
- A claim/complete register pair serialises service: one source at a time is handed to software.
- The block sits on the data bus as a chip-selected device with 4-bit word addressing.

Parameters:
- N_SRC, 8, number of interrupt sources; IDs 1..N_SRC; ID 0 means "none"; legal range 1..8.
- PRIO_W, 3, priority width; 0 = never interrupts; larger value = more urgent.

Ports:
- clk_in  input  1  single clock; all state updates on the rising edge.
- rst_in  input  1  reset, synchronous and active-high.
- CS  input  1  device select; one bus access per cycle in which it is high.
- irq_in  input  N_SRC  level interrupt requests; bit i-1 is source ID i.
- dbus_we  input  1  1 = write, 0 = read.
- dbus_addr4  input  4  word address.
- dbus_in  input  32  write data.
- dbus_out  output  32  read data.
- irq_out  output  1  registered interrupt request to the CPU core.

Behaviour:
- Register map (word addresses); reads of unmapped addresses return 0, writes to them are ignored:
  - 0x0 PENDING, RO: bit i-1 = source i pending.
  - 0x1 ENABLE, RW: bits N_SRC-1:0.
  - 0x2 THRESHOLD, RW: bits PRIO_W-1:0.
  - 0x3 CLAIM/COMPLETE: a read claims; a write completes.
  - 0x4 PRIORITY, RW: nibble i-1 = priority of source i; only the low PRIO_W bits of each nibble are stored; other bits read 0.
  - 0x5 INSERVICE, RO: bit i-1 = source i claimed.
- dbus_out is combinational. It equals the addressed register when CS=1 and dbus_we=0; otherwise it is 0.
- Writes take effect at the clock edge of the cycle in which CS=1 and dbus_we=1.
- Reset values: all gateways IDLE; ENABLE, THRESHOLD, PRIORITY = 0; best_id = 0; irq_out = 0.
- Gateway FSM, one per source:
  - IDLE -> PEND when irq_in is high at the edge.
  - PEND -> CLAIMED on a claim of this ID.
  - CLAIMED -> IDLE on a complete of this ID.
  - irq_in is ignored in PEND and CLAIMED, so a source cannot re-pend until it is completed.
  - Pending does not drop if irq_in falls while in PEND.
- Arbitration:
  - Candidates are sources with pending & enable & (prio > threshold).
  - Highest priority wins; ties go to the lowest ID.
  - The result is registered into best_id every cycle; irq_out is registered as (next best_id != 0).
- Latency:
  - irq_in rising before edge E0 gives pending after E0 and best_id/irq_out after E1.
  - ENABLE, PRIORITY and THRESHOLD changes reach irq_out one edge after the write edge.
- Claim (read of 0x3):
  - Returns the current best_id.
  - If it is nonzero, that gateway moves PEND -> CLAIMED at the edge.
  - At that same edge best_id and irq_out are forced to 0; arbitration resumes the following edge. This guarantees back-to-back claims never return the same ID.
  - A claim that returns 0 has no side effect.
- Complete (write of 0x3): dbus_in[3:0] = ID. Ignored when the ID is 0, greater than N_SRC, or not in CLAIMED.
- Simultaneous events:
  - A complete and irq_in high on the same source in the same cycle leaves the gateway IDLE after the edge; it re-pends on the next edge.
  - A claim and a PRIORITY/ENABLE write in the same cycle cannot occur, since there is one access per cycle.
- Disabling an enabled, pending source leaves it in PEND; it is only excluded from arbitration.
- Reset asserted mid-service (CLAIMED) returns every gateway to IDLE and clears all registers.

Decomposition:
- Shared package plic_pkg holds:
  - address constants ADDR_PENDING .. ADDR_INSERVICE;
  - the gateway state enum gw_state_t {GW_IDLE, GW_PEND, GW_CLAIMED};
  - the ID width constant (4).
- Sub-module plic_gateway: one instance per source, generated. Inputs: irq, claim, complete, rst_in. Outputs: pending, in_service.
- The arbiter, register file and bus decode stay in plic_arbiter.

Test Plan:
- Reset, then read all registers -> all read 0 and irq_out = 0; irq_in = 0xFF with priority 0 -> irq_out stays 0.
- PRIORITY = 0x00000321 (sources 1,2,3 = 1,2,3), ENABLE = 0x07, THRESHOLD = 0, irq_in = 0x07 -> irq_out high 2 cycles after irq_in rises; claims return 3, 2, 1, then 0; INSERVICE = 0x07.
- Sources 2 and 5 at equal priority 4, both pending -> claim returns 2; PENDING = 0x10 afterwards; irq_out drops for exactly 1 cycle and then reasserts.
- THRESHOLD = 4 with a source at priority 4 pending -> irq_out = 0; write THRESHOLD = 3 -> irq_out = 1 two edges later.
- Claim ID 1, hold irq_in[0] high, write complete 1 -> PENDING bit 0 set one edge later; complete of ID 6 (never claimed) and complete of ID 0 -> no state change.
- Assert rst_in while ID 3 is CLAIMED -> INSERVICE = 0, ENABLE = 0, irq_out = 0 after the edge.

Source files
------------

// File: rtl/plic_pkg.sv
// Shared constants and types for the PLIC-style interrupt arbiter.
package plic_pkg;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NIB_W  = 4;

  localparam logic [ADDR_W-1:0] ADDR_PENDING   = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_ENABLE    = 4'h1;
  localparam logic [ADDR_W-1:0] ADDR_THRESHOLD = 4'h2;
  localparam logic [ADDR_W-1:0] ADDR_CLAIM     = 4'h3;
  localparam logic [ADDR_W-1:0] ADDR_PRIORITY  = 4'h4;
  localparam logic [ADDR_W-1:0] ADDR_INSERVICE = 4'h5;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PEND    = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_t;

endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: latches a request as pending, holds it through service
// and ignores the request line until software completes it.
module plic_gateway
  import plic_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  input  logic irq_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o,
  output logic in_service_o
);

  gw_state_t state_q;
  gw_state_t state_d;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= GW_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GW_IDLE:    if (irq_i)      state_d = GW_PEND;
      GW_PEND:    if (claim_i)    state_d = GW_CLAIMED;
      GW_CLAIMED: if (complete_i) state_d = GW_IDLE;
      default:                    state_d = GW_IDLE;
    endcase
  end

  assign pending_o    = (state_q == GW_PEND);
  assign in_service_o = (state_q == GW_CLAIMED);

endmodule

// File: rtl/plic_arbiter.sv
// Interrupt arbiter: per-source gateways, enable/priority/threshold registers,
// priority selection and the claim/complete handshake on a 4-bit word bus.
module plic_arbiter
  import plic_pkg::*;
#(
  parameter int unsigned N_SRC  = 8,
  parameter int unsigned PRIO_W = 3
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              CS,
  input  logic [N_SRC-1:0]  irq_in,
  input  logic              dbus_we,
  input  logic [ADDR_W-1:0] dbus_addr4,
  input  logic [DATA_W-1:0] dbus_in,
  output logic [DATA_W-1:0] dbus_out,
  output logic              irq_out
);

  logic [N_SRC-1:0]             enable_q, enable_d;
  logic [PRIO_W-1:0]            thresh_q, thresh_d;
  logic [N_SRC-1:0][PRIO_W-1:0] prio_q, prio_d;
  logic [ID_W-1:0]              best_id_q, best_id_d;
  logic                         irq_q, irq_d;

  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] in_service;
  logic [N_SRC-1:0] claim_vec;
  logic [N_SRC-1:0] complete_vec;
  logic             wr_en;
  logic             rd_en;
  logic             claim_c;
  logic             complete_c;
  logic [ID_W-1:0]  arb_id;
  logic [PRIO_W-1:0] arb_prio;
  logic             unused_dbus;

  assign wr_en      = CS & dbus_we;
  assign rd_en      = CS & ~dbus_we;
  assign claim_c    = rd_en && (dbus_addr4 == ADDR_CLAIM) && (best_id_q != '0);
  assign complete_c = wr_en && (dbus_addr4 == ADDR_CLAIM);
  assign unused_dbus = ^dbus_in;

  // IDs 0 and above N_SRC match no gateway, so such completes fall away here.
  for (genvar g = 0; g < N_SRC; g++) begin : g_gw
    assign claim_vec[g]    = claim_c && (best_id_q == ID_W'(g + 1));
    assign complete_vec[g] = complete_c && (dbus_in[ID_W-1:0] == ID_W'(g + 1));

    plic_gateway u_gw (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .irq_i        (irq_in[g]),
      .claim_i      (claim_vec[g]),
      .complete_i   (complete_vec[g]),
      .pending_o    (pending[g]),
      .in_service_o (in_service[g])
    );
  end

  always_comb begin
    enable_d = enable_q;
    thresh_d = thresh_q;
    prio_d   = prio_q;
    if (wr_en) begin
      case (dbus_addr4)
        ADDR_ENABLE:    enable_d = dbus_in[N_SRC-1:0];
        ADDR_THRESHOLD: thresh_d = dbus_in[PRIO_W-1:0];
        ADDR_PRIORITY: begin
          for (int unsigned i = 0; i < N_SRC; i++) begin
            prio_d[i] = dbus_in[NIB_W*i +: PRIO_W];
          end
        end
        default: ;
      endcase
    end
  end

  // Strict '>' keeps the lowest ID on a priority tie; candidates always have prio >= 1.
  always_comb begin
    arb_id   = '0;
    arb_prio = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (pending[i] && enable_q[i] && (prio_q[i] > thresh_q) && (prio_q[i] > arb_prio)) begin
        arb_id   = ID_W'(i + 1);
        arb_prio = prio_q[i];
      end
    end
  end

  // A claim blanks the selection for one edge so a second claim cannot repeat the ID.
  always_comb begin
    best_id_d = claim_c ? '0 : arb_id;
    irq_d     = (best_id_d != '0);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      enable_q  <= '0;
      thresh_q  <= '0;
      prio_q    <= '0;
      best_id_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      enable_q  <= enable_d;
      thresh_q  <= thresh_d;
      prio_q    <= prio_d;
      best_id_q <= best_id_d;
      irq_q     <= irq_d;
    end
  end

  assign irq_out = irq_q;

  always_comb begin
    dbus_out = '0;
    if (rd_en) begin
      case (dbus_addr4)
        ADDR_PENDING:   dbus_out = DATA_W'(pending);
        ADDR_ENABLE:    dbus_out = DATA_W'(enable_q);
        ADDR_THRESHOLD: dbus_out = DATA_W'(thresh_q);
        ADDR_CLAIM:     dbus_out = DATA_W'(best_id_q);
        ADDR_PRIORITY: begin
          for (int unsigned i = 0; i < N_SRC; i++) begin
            dbus_out[NIB_W*i +: PRIO_W] = prio_q[i];
          end
        end
        ADDR_INSERVICE: dbus_out = DATA_W'(in_service);
        default:        dbus_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_plic_arbiter.sv
// Directed bench for plic_arbiter; expected values queue up as stimulus is
// issued and are popped when the DUT output is sampled.
module tb_plic_arbiter;
  import plic_pkg::*;

  localparam int unsigned N_SRC  = 8;
  localparam int unsigned PRIO_W = 3;

  logic              clk_in;
  logic              rst_in;
  logic              CS;
  logic [N_SRC-1:0]  irq_in;
  logic              dbus_we;
  logic [3:0]        dbus_addr4;
  logic [31:0]       dbus_in;
  logic [31:0]       dbus_out;
  logic              irq_out;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests;
  int   n_fail;

  plic_arbiter #(.N_SRC(N_SRC), .PRIO_W(PRIO_W)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .CS         (CS),
    .irq_in     (irq_in),
    .dbus_we    (dbus_we),
    .dbus_addr4 (dbus_addr4),
    .dbus_in    (dbus_in),
    .dbus_out   (dbus_out),
    .irq_out    (irq_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check_out(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    CS         = 1'b1;
    dbus_we    = 1'b1;
    dbus_addr4 = addr;
    dbus_in    = data;
    tick();
    CS      = 1'b0;
    dbus_we = 1'b0;
    dbus_in = '0;
  endtask

  task automatic bus_read(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    push_exp(tag, exp);
    CS         = 1'b1;
    dbus_we    = 1'b0;
    dbus_addr4 = addr;
    #1;
    check_out(dbus_out);
    tick();
    CS = 1'b0;
  endtask

  task automatic expect_irq(input string tag, input logic exp);
    push_exp(tag, 32'(exp));
    check_out(32'(irq_out));
  endtask

  task automatic do_reset();
    rst_in  = 1'b1;
    CS      = 1'b0;
    dbus_we = 1'b0;
    irq_in  = '0;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_in     = 1'b1;
    CS         = 1'b0;
    dbus_we    = 1'b0;
    dbus_addr4 = '0;
    dbus_in    = '0;
    irq_in     = '0;
    repeat (3) tick();
    rst_in = 1'b0;

    // Reset state and priority-0 sources never interrupting
    expect_irq("rst_irq", 1'b0);
    for (int a = 0; a < 8; a++) begin
      bus_read($sformatf("rst_reg%0d", a), 4'(a), 32'h0);
    end
    irq_in = 8'hFF;
    repeat (3) tick();
    expect_irq("prio0_irq", 1'b0);
    bus_read("prio0_pending", ADDR_PENDING, 32'hFF);
    bus_read("prio0_claim", ADDR_CLAIM, 32'h0);
    do_reset();

    // Three sources at distinct priorities, claimed in priority order
    bus_write(ADDR_PRIORITY, 32'h0000_0321);
    bus_write(ADDR_ENABLE, 32'h07);
    bus_write(ADDR_THRESHOLD, 32'h0);
    bus_read("t2_prio_rd", ADDR_PRIORITY, 32'h0000_0321);
    irq_in = 8'h07;
    tick();
    expect_irq("t2_irq_e0", 1'b0);
    irq_in = 8'h00;
    tick();
    expect_irq("t2_irq_e1", 1'b1);
    bus_read("t2_claim3", ADDR_CLAIM, 32'd3);
    expect_irq("t2_irq_blank", 1'b0);
    tick();
    bus_read("t2_claim2", ADDR_CLAIM, 32'd2);
    tick();
    bus_read("t2_claim1", ADDR_CLAIM, 32'd1);
    tick();
    bus_read("t2_claim0", ADDR_CLAIM, 32'd0);
    bus_read("t2_inservice", ADDR_INSERVICE, 32'h07);
    bus_read("t2_pending", ADDR_PENDING, 32'h00);
    bus_write(ADDR_CLAIM, 32'd1);
    bus_write(ADDR_CLAIM, 32'd2);
    bus_write(ADDR_CLAIM, 32'd3);
    bus_read("t2_inservice_clr", ADDR_INSERVICE, 32'h00);

    // Equal priority tie goes to the lower ID; irq blanks for one cycle
    bus_write(ADDR_PRIORITY, 32'h0004_0040);
    bus_write(ADDR_ENABLE, 32'h12);
    irq_in = 8'h12;
    tick();
    irq_in = 8'h00;
    tick();
    expect_irq("t3_irq", 1'b1);
    bus_read("t3_claim2", ADDR_CLAIM, 32'd2);
    expect_irq("t3_irq_drop", 1'b0);
    bus_read("t3_pending", ADDR_PENDING, 32'h10);
    expect_irq("t3_irq_back", 1'b1);
    bus_read("t3_claim5", ADDR_CLAIM, 32'd5);
    bus_write(ADDR_CLAIM, 32'd2);
    bus_write(ADDR_CLAIM, 32'd5);
    bus_read("t3_inservice_clr", ADDR_INSERVICE, 32'h00);

    // Threshold equal to priority masks; lowering it unmasks after one edge
    bus_write(ADDR_THRESHOLD, 32'd4);
    irq_in = 8'h02;
    tick();
    irq_in = 8'h00;
    tick();
    tick();
    expect_irq("t4_irq_masked", 1'b0);
    bus_read("t4_pending", ADDR_PENDING, 32'h02);
    bus_write(ADDR_THRESHOLD, 32'd3);
    expect_irq("t4_irq_wr_edge", 1'b0);
    tick();
    expect_irq("t4_irq_unmasked", 1'b1);
    bus_read("t4_claim2", ADDR_CLAIM, 32'd2);
    bus_write(ADDR_CLAIM, 32'd2);

    // Priority field truncation, complete with request held, bogus completes
    bus_write(ADDR_THRESHOLD, 32'd0);
    bus_write(ADDR_PRIORITY, 32'hFFFF_FFFF);
    bus_read("t5_prio_trunc", ADDR_PRIORITY, 32'h7777_7777);
    bus_write(ADDR_PRIORITY, 32'h0000_0005);
    bus_write(ADDR_ENABLE, 32'h01);
    irq_in = 8'h01;
    tick();
    tick();
    expect_irq("t5_irq", 1'b1);
    bus_read("t5_claim1", ADDR_CLAIM, 32'd1);
    bus_read("t5_inservice", ADDR_INSERVICE, 32'h01);
    bus_write(ADDR_CLAIM, 32'd1);
    bus_read("t5_pending_idle", ADDR_PENDING, 32'h00);
    bus_read("t5_pending_repend", ADDR_PENDING, 32'h01);
    irq_in = 8'h00;
    bus_read("t5_claim1_again", ADDR_CLAIM, 32'd1);
    bus_write(ADDR_CLAIM, 32'd0);
    bus_write(ADDR_CLAIM, 32'd6);
    bus_write(ADDR_CLAIM, 32'd9);
    bus_read("t5_bogus_inservice", ADDR_INSERVICE, 32'h01);
    bus_read("t5_bogus_pending", ADDR_PENDING, 32'h00);
    bus_write(ADDR_CLAIM, 32'd1);
    bus_read("t5_inservice_clr", ADDR_INSERVICE, 32'h00);

    // Reset while a source is in service
    bus_write(ADDR_PRIORITY, 32'h0000_0301);
    bus_write(ADDR_ENABLE, 32'h05);
    irq_in = 8'h05;
    tick();
    irq_in = 8'h00;
    tick();
    bus_read("t6_claim3", ADDR_CLAIM, 32'd3);
    tick();
    expect_irq("t6_irq_src1", 1'b1);
    bus_read("t6_inservice", ADDR_INSERVICE, 32'h04);
    rst_in = 1'b1;
    tick();
    expect_irq("t6_rst_irq", 1'b0);
    rst_in = 1'b0;
    bus_read("t6_rst_inservice", ADDR_INSERVICE, 32'h00);
    bus_read("t6_rst_enable", ADDR_ENABLE, 32'h00);
    bus_read("t6_rst_pending", ADDR_PENDING, 32'h00);
    bus_read("t6_rst_priority", ADDR_PRIORITY, 32'h00);
    bus_read("t6_rst_claim", ADDR_CLAIM, 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
